// File: rtl/jtgng_dwnld_pkg.sv
// Shared definitions for the ROM download packer: write-FSM encodings and default filler byte.
package jtgng_dwnld_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } wr_state_t;

   localparam logic [7:0] DEF_PAD = 8'hFF;

endpackage

// File: rtl/jtgng_dwnld_fifo.sv
// Small word FIFO with two write ports (port 0 lands first) and one read port.
// Words that do not fit are dropped and reported on drop for that cycle.
module jtgng_dwnld_fifo #(
   parameter int DW      = 37,
   parameter int FIFO_AW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we0,
   input  logic [DW-1:0]     din0,
   input  logic              we1,
   input  logic [DW-1:0]     din1,
   input  logic              pop,
   output logic [DW-1:0]     head,
   output logic              full,
   output logic              empty,
   output logic [FIFO_AW:0]  count,
   output logic              drop
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int PW    = FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_V = CW'(DEPTH);

   logic [DW-1:0]      mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_AW:0]   cnt_reg;
   logic [FIFO_AW:0]   space0, space1;
   logic [FIFO_AW-1:0] slot1;
   logic               acc0, acc1, do_pop;

   // A pop in the same cycle frees its slot, so a full FIFO still takes a push.
   always_comb begin
      do_pop = pop && (cnt_reg != '0);
      space0 = DEPTH_V - cnt_reg + CW'(do_pop);
      acc0   = we0 && (space0 != '0);
      space1 = space0 - CW'(acc0);
      acc1   = we1 && (space1 != '0);
      slot1  = wr_ptr_reg + PW'(acc0);
   end

   always_ff @(posedge clk) begin
      if (acc0) mem[wr_ptr_reg] <= din0;
      if (acc1) mem[slot1]      <= din1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + PW'(acc0) + PW'(acc1);
         rd_ptr_reg <= rd_ptr_reg + PW'(do_pop);
         cnt_reg    <= cnt_reg + CW'(acc0) + CW'(acc1) - CW'(do_pop);
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = cnt_reg;
   assign empty = (cnt_reg == '0);
   assign full  = (cnt_reg == DEPTH_V);
   assign drop  = (we0 && !acc0) || (we1 && !acc1);

endmodule

// File: rtl/jtgng_dwnld.sv
// Packs the byte-serial ROM download into 16-bit words, buffers them and writes them
// to SDRAM through a req/ack handshake; reports loading, done, overflow and word count.
module jtgng_dwnld
   import jtgng_dwnld_pkg::*;
#(
   parameter int         AW      = 22,
   parameter int         FIFO_AW = 2,
   parameter logic [7:0] PAD     = DEF_PAD
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          downloading,
   input  logic          ioctl_wr,
   input  logic [AW-1:0] ioctl_addr,
   input  logic [7:0]    ioctl_data,
   output logic          sdram_req,
   output logic [AW-2:0] sdram_addr,
   output logic [15:0]   sdram_data,
   input  logic          sdram_ack,
   output logic          loading,
   output logic          done,
   output logic          overflow,
   output logic [AW-2:0] word_cnt
);

   localparam int WW = AW - 1;
   localparam int DW = WW + 16;

   logic            dl_last_reg;
   logic            pend_valid_reg;
   logic [7:0]      pend_data_reg;
   logic [WW-1:0]   pend_wa_reg;
   logic            loading_reg, done_reg, overflow_reg;
   logic [WW-1:0]   word_cnt_reg;
   logic            req_reg;
   logic [WW-1:0]   addr_reg;
   logic [15:0]     data_reg;
   wr_state_t       state_reg, state_next;

   logic            dl_rise, strobe, pend_load, pend_clr;
   logic [WW-1:0]   byte_wa;
   logic            we0, we1, pop, load_head, idle_cond;
   logic [DW-1:0]   din0, din1, head;
   logic            fifo_full, fifo_empty, fifo_drop;
   logic [FIFO_AW:0] fifo_count;
   logic            fifo_unused;

   assign dl_rise = downloading && !dl_last_reg;
   assign strobe  = ioctl_wr && downloading;
   assign byte_wa = ioctl_addr[AW-1:1];

   // Port 0 always carries the older word (a pending flush) so ordering is preserved.
   always_comb begin
      we0       = 1'b0;
      we1       = 1'b0;
      din0      = {pend_wa_reg, PAD, pend_data_reg};
      din1      = {byte_wa, ioctl_data, PAD};
      pend_load = 1'b0;
      pend_clr  = 1'b0;
      if (strobe) begin
         if (!ioctl_addr[0]) begin
            we0       = pend_valid_reg;
            pend_load = 1'b1;
         end else if (pend_valid_reg && (pend_wa_reg == byte_wa)) begin
            we0      = 1'b1;
            din0     = {byte_wa, ioctl_data, pend_data_reg};
            pend_clr = 1'b1;
         end else begin
            we0      = pend_valid_reg;
            we1      = 1'b1;
            pend_clr = 1'b1;
         end
      end else if (!downloading && pend_valid_reg) begin
         we0      = 1'b1;
         pend_clr = 1'b1;
      end
   end

   jtgng_dwnld_fifo #(
      .DW      (DW),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .we0   (we0),
      .din0  (din0),
      .we1   (we1),
      .din1  (din1),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .drop  (fifo_drop)
   );

   assign fifo_unused = ^{fifo_full, fifo_count};

   always_comb begin
      state_next = state_reg;
      load_head  = 1'b0;
      pop        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               load_head  = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sdram_ack) begin
               pop        = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // The in-flight word stays at the FIFO head until acked, so an empty FIFO means nothing is owed.
   assign idle_cond = !downloading && !pend_valid_reg && fifo_empty && (state_reg == ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_last_reg    <= 1'b0;
         pend_valid_reg <= 1'b0;
         pend_data_reg  <= '0;
         pend_wa_reg    <= '0;
         state_reg      <= ST_IDLE;
         req_reg        <= 1'b0;
         addr_reg       <= '0;
         data_reg       <= '0;
         word_cnt_reg   <= '0;
         overflow_reg   <= 1'b0;
         loading_reg    <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         dl_last_reg <= downloading;

         if (pend_load) begin
            pend_valid_reg <= 1'b1;
            pend_data_reg  <= ioctl_data;
            pend_wa_reg    <= byte_wa;
         end else if (pend_clr) begin
            pend_valid_reg <= 1'b0;
         end

         state_reg <= state_next;
         if (load_head) begin
            req_reg  <= 1'b1;
            addr_reg <= head[DW-1:16];
            data_reg <= head[15:0];
         end else if (pop) begin
            req_reg <= 1'b0;
         end

         if (dl_rise) word_cnt_reg <= '0;
         else         word_cnt_reg <= word_cnt_reg + WW'(pop);

         if (dl_rise)        overflow_reg <= fifo_drop;
         else if (fifo_drop) overflow_reg <= 1'b1;

         if (dl_rise)                       loading_reg <= 1'b1;
         else if (loading_reg && idle_cond) loading_reg <= 1'b0;
         done_reg <= loading_reg && idle_cond;
      end
   end

   assign sdram_req  = req_reg;
   assign sdram_addr = addr_reg;
   assign sdram_data = data_reg;
   assign loading    = loading_reg;
   assign done       = done_reg;
   assign overflow   = overflow_reg;
   assign word_cnt   = word_cnt_reg;

endmodule
